ssd_scan_controller: RTL

//  Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display.

---
 rtl/ssd_pkg.sv | 38 +++
 rtl/ssd_hex_decoder.sv | 11 +
 rtl/ssd_scan_controller.sv | 105 ++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared types and the hex-to-segment truth table for the seven-segment scan controller.
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_t;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational 4-bit hex to 7-bit active-low segment decoder.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/ssd_scan_controller.sv
// Four-digit common-anode display scanner with per-slot blanking and frame-boundary updates.
// Optional build macro SSD_LZ_BLANK_EN blanks leading-zero digits (digit 0 always shown).
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned DIV_W        = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        frame_tick
);

    localparam logic [DIV_W-1:0] CNT_LAST       = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] CNT_BLANK_LAST = DIV_W'(BLANK_CYCLES - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    digit_idx_t       digit_q, digit_d;
    scan_state_t      state_q, state_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       anode_q, anode_d;
    logic [6:0]       cathode_q, cathode_d;
    logic             tick_q;

    logic             slot_last;
    logic             frame_bound;
    logic             lz_blank;
    logic [3:0]       nibble;
    logic [6:0]       seg;

    assign nibble = shadow_q[{digit_q, 2'b00} +: 4];

    ssd_hex_decoder u_dec (
        .nibble_i (nibble),
        .seg_o    (seg)
    );

`ifdef SSD_LZ_BLANK_EN
    assign lz_blank = (digit_q != 2'd0) && ((shadow_q >> {digit_q, 2'b00}) == 16'h0000);
`else
    assign lz_blank = 1'b0;
`endif

    assign slot_last   = (cnt_q == CNT_LAST);
    assign frame_bound = en && (digit_q == 2'd3) && slot_last;

    always_comb begin
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        state_d  = state_q;
        shadow_d = shadow_q;
        // While dark the counter is parked at 0 in BLANK, so re-enable restarts the same digit's slot.
        if (!en) begin
            cnt_d   = '0;
            state_d = BLANK;
        end else if (slot_last) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            state_d = BLANK;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == BLANK && cnt_q == CNT_BLANK_LAST) begin
                state_d = SHOW;
            end
        end
        if (frame_bound && upd_valid) begin
            shadow_d = upd_data;
        end
        anode_d   = (en && state_q == SHOW) ? ~(4'b0001 << digit_q) : ANODE_OFF;
        cathode_d = lz_blank ? SEG_BLANK : seg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            digit_q   <= '0;
            state_q   <= BLANK;
            shadow_q  <= '0;
            anode_q   <= ANODE_OFF;
            cathode_q <= SEG_BLANK;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
            tick_q    <= frame_bound;
        end
    end

    assign upd_ready  = frame_bound;
    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign frame_tick = tick_q;

endmodule
